torwave_rx_check: RTL and testbench
===================================

Name: torwave_rx_check

Overview:
- AXI-Stream slave receiver/checker for the 64-bit torwave frame stream; the receive-end counterpart of the torwave generator's master output.
- Accepts frames delimited by tuser (start of frame, SOF) and tlast (end of frame, EOF).
- Checks frame length, SOF-to-SOF period against the 10 ms budget, and SOF alignment to radio_start_10ms.
- Captures one armed frame into local RAM for register/debug readback; used in loopback and board bring-up.

Parameters:
- capture_word_depth, 1024, capture RAM depth in 64-bit words; power of two.
- clocks_for_10ms, 4000000, nominal SOF-to-SOF period in clocks.
- period_tolerance, 16, allowed ± deviation from clocks_for_10ms, in clocks.
- expected_frame_words, 0, required beats per frame; 0 disables the length check.

Ports:
- s_axis_aclk  in  1  sole clock.
- s_axis_areset  in  1  synchronous, active-high reset.
- s_data_tdata  in  64  stream data.
- s_data_tkeep  in  8  byte enables.
- s_data_tvalid  in  1  beat valid.
- s_data_tlast  in  1  end of frame.
- s_data_tuser  in  1  start of frame.
- s_data_tready  out  1  ready.
- radio_start_10ms  in  1  one-cycle 10 ms start pulse.
- capture_arm  in  1  pulse; capture the next frame.
- err_clear  in  1  pulse; clear sticky errors and the period reference.
- rd_addr  in  log2(capture_word_depth)  capture RAM read address.
- rd_data  out  64  capture RAM read data.
- capture_done  out  1  armed capture complete.
- capture_words  out  16  beats stored by the last capture.
- frame_count  out  32  completed frames; wraps.
- last_frame_words  out  16  beat count of the last EOF'd frame.
- last_period  out  32  clocks between the last two SOFs.
- start_to_sof  out  32  clocks from the last radio_start_10ms to the last SOF.
- err_status  out  4  sticky errors: [0] length, [1] period, [2] SOF/orphan, [3] keep.
- error_flag  out  1  OR of err_status.

Behaviour:
- Reset: all outputs 0, except start_to_sof = 0xFFFFFFFF.
  - State returns to IDLE; capture is disarmed; period reference is invalid.
  - Reset mid-frame drops the frame without counting it.
- s_data_tready: 0 while reset is asserted, then 1 from the first cycle after reset deasserts. A beat is accepted when tvalid & tready.
- FSM IDLE:
  - Accepted beat with tuser=1 → IN_FRAME; word counter = 1.
  - Accepted beat with tuser=0 → discarded; sets err[2].
  - Accepted beat with tuser=1 and tlast=1 → one-beat frame; stays IDLE.
- FSM IN_FRAME:
  - Each accepted beat increments the 16-bit word counter, which saturates at 0xFFFF.
  - tlast → IDLE. frame_count+1, last_frame_words updated.
  - Length check at EOF: if expected_frame_words≠0 and count≠expected, set err[0].
  - tuser=1 mid-frame: set err[2] and err[0]; the truncated frame is not counted; the beat starts a new frame with count = 1.
- Period check at every SOF:
  - A free-running 32-bit counter saturates at 0xFFFFFFFF.
  - If the reference is valid: last_period = counter; set err[1] if |counter − clocks_for_10ms| > period_tolerance.
  - Then counter = 1 and the reference becomes valid.
  - The first SOF after reset or err_clear performs no check.
- Alignment:
  - radio_start_10ms clears the alignment counter to 0; it then counts up and saturates.
  - At SOF, start_to_sof = counter value, or 0xFFFFFFFF if no pulse has been seen since reset.
  - A pulse and an SOF in the same cycle give start_to_sof = 0.
- Capture:
  - capture_arm sets armed and clears capture_done; it is ignored while a capture is in progress.
  - The next SOF beat writes RAM address 0; subsequent beats write incrementing addresses.
  - Capture stops at EOF or after capture_word_depth beats; later beats of that frame are not stored.
  - capture_words = number stored; capture_done = 1 the cycle after the stop condition; armed is cleared.
  - A mid-frame SOF ends the capture at the truncation point.
- rd_data: registered, 1-cycle latency from rd_addr; reads are permitted during capture.
- err_clear: clears err_status and invalidates the period reference. A same-cycle error event wins, so that bit stays set.
- error_flag: registered OR of err_status; 1 cycle after the error bit sets.

Optional Feature:
- Macro: TORWAVE_RX_KEEP_CHECK_EN.
- Defined:
  - Non-last beats must have tkeep=0xFF.
  - Last beats must have contiguous tkeep from bit 0 and be nonzero (0x01, 0x03, … 0xFF).
  - A violation sets err[3].
- Undefined: tkeep is ignored; err[3] is tied to 0.

Test Plan (clocks_for_10ms=100, period_tolerance=2, expected_frame_words=8, capture_word_depth=16):
- Reset, then frames of 8 beats with SOFs 100 clocks apart → frame_count=3, last_frame_words=8, last_period=100, err_status=0.
- SOF spacing of 103 clocks → err[1]=1 and error_flag=1 one cycle later; spacing of 98 → no error; err_clear → err_status=0.
- Frame of 7 beats, then a frame with tuser on beat 5 → err[0] and err[2] set; frame_count counts only completed frames.
- capture_arm, then a 20-beat frame with data = beat index → capture_words=16; rd_addr=5 gives rd_data=5 one cycle later; capture_done=1.
- radio_start_10ms pulse, then SOF 37 clocks later → start_to_sof=37; SOF with no prior pulse after reset → 0xFFFFFFFF.
- With TORWAVE_RX_KEEP_CHECK_EN: last beat tkeep=0x05 → err[3]=1; without the macro, the same stimulus → err[3]=0.

Source files
------------

// File: rtl/torwave_rx_check.sv
// torwave_rx_check: AXI-Stream torwave frame receiver, checker and capture RAM.
// Define TORWAVE_RX_KEEP_CHECK_EN to enable tkeep validity checking (err[3]).
module torwave_rx_check #(
  parameter int capture_word_depth   = 1024,
  parameter int clocks_for_10ms      = 4000000,
  parameter int period_tolerance     = 16,
  parameter int expected_frame_words = 0,
  localparam int aw = $clog2(capture_word_depth)
) (
  input  logic          s_axis_aclk,
  input  logic          s_axis_areset,
  input  logic [63:0]   s_data_tdata,
  input  logic [7:0]    s_data_tkeep,
  input  logic          s_data_tvalid,
  input  logic          s_data_tlast,
  input  logic          s_data_tuser,
  output logic          s_data_tready,
  input  logic          radio_start_10ms,
  input  logic          capture_arm,
  input  logic          err_clear,
  input  logic [aw-1:0] rd_addr,
  output logic [63:0]   rd_data,
  output logic          capture_done,
  output logic [15:0]   capture_words,
  output logic [31:0]   frame_count,
  output logic [15:0]   last_frame_words,
  output logic [31:0]   last_period,
  output logic [31:0]   start_to_sof,
  output logic [3:0]    err_status,
  output logic          error_flag
);

  typedef enum logic {idle_s, frame_s} state_t;

  localparam logic [33:0] per_c   = 34'(clocks_for_10ms);
  localparam logic [33:0] per_tol = 34'(period_tolerance);
  localparam logic [aw:0] cap_full = (aw+1)'(capture_word_depth);

  state_t        state, state_nx;
  logic          rdy_q, acc, sof, eof, orphan, trunc;
  logic          len_err, per_err, keep_err;
  logic [15:0]   wc, wc_nx;
  logic [31:0]   per_cnt, aln_cnt;
  logic          ref_valid, aln_seen;
  logic [3:0]    err_q, err_set;
  logic          armed, cap_act, cap_first, cap_wr, cap_stop;
  logic [aw:0]   cap_cnt, cap_cnt_nx;
  logic [aw-1:0] cap_addr;
  logic [63:0]   mem [capture_word_depth];

  assign s_data_tready = rdy_q & ~s_axis_areset;
  assign acc = s_data_tvalid & s_data_tready;
  assign err_status = err_q;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) state <= idle_s;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      idle_s:  if (acc && s_data_tuser && !s_data_tlast) state_nx = frame_s;
      frame_s: if (acc && s_data_tlast) state_nx = idle_s;
      default: state_nx = idle_s;
    endcase
  end

  always_comb begin
    sof     = acc & s_data_tuser;
    orphan  = acc & ~s_data_tuser & (state == idle_s);
    trunc   = sof & (state == frame_s);
    eof     = acc & s_data_tlast & (s_data_tuser | (state == frame_s));
    wc_nx   = s_data_tuser ? 16'd1 : ((wc == 16'hffff) ? wc : wc + 16'd1);
    len_err = trunc | (eof && expected_frame_words != 0 &&
                       wc_nx != 16'(expected_frame_words));
    per_err = sof & ref_valid &
              (({2'b0, per_cnt} > per_c + per_tol) |
               (({2'b0, per_cnt} + per_tol) < per_c));
`ifdef TORWAVE_RX_KEEP_CHECK_EN
    // last beat: nonzero and contiguous from bit 0
    keep_err = acc & (s_data_tlast ?
               (s_data_tkeep == 8'h00 ||
                (s_data_tkeep & (s_data_tkeep + 8'd1)) != 8'h00) :
               (s_data_tkeep != 8'hff));
`else
    keep_err = 1'b0;
`endif
    err_set = {keep_err, orphan | trunc, per_err, len_err};
  end

`ifndef TORWAVE_RX_KEEP_CHECK_EN
  logic keep_unused;
  assign keep_unused = ^s_data_tkeep;
`endif

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      rdy_q            <= 1'b0;
      wc               <= '0;
      frame_count      <= '0;
      last_frame_words <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (acc && (s_data_tuser || state == frame_s)) wc <= wc_nx;
      if (eof) begin
        frame_count      <= frame_count + 32'd1;
        last_frame_words <= wc_nx;
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      per_cnt      <= '0;
      ref_valid    <= 1'b0;
      last_period  <= '0;
      aln_cnt      <= '0;
      aln_seen     <= 1'b0;
      start_to_sof <= '1;
    end else begin
      if (sof)                   per_cnt <= 32'd1;
      else if (per_cnt != '1)    per_cnt <= per_cnt + 32'd1;
      if (sof) begin
        ref_valid <= 1'b1;
        if (ref_valid) last_period <= per_cnt;
      end else if (err_clear) begin
        ref_valid <= 1'b0;
      end
      // aln_cnt holds clocks since the pulse as seen by the next edge
      if (radio_start_10ms)      aln_cnt <= 32'd1;
      else if (aln_cnt != '1)    aln_cnt <= aln_cnt + 32'd1;
      if (radio_start_10ms)      aln_seen <= 1'b1;
      if (sof)
        start_to_sof <= radio_start_10ms ? 32'd0 :
                        (aln_seen ? aln_cnt : '1);
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      err_q      <= '0;
      error_flag <= 1'b0;
    end else begin
      err_q      <= (err_clear ? 4'd0 : err_q) | err_set;
      error_flag <= |err_q;
    end
  end

  always_comb begin
    cap_first  = sof & armed & ~cap_act;
    cap_wr     = cap_first | (acc & cap_act & ~s_data_tuser);
    cap_cnt_nx = cap_first ? (aw+1)'(1) : cap_cnt + (aw+1)'(1);
    cap_addr   = cap_first ? '0 : cap_cnt[aw-1:0];
    cap_stop   = (cap_act & sof) |
                 (cap_wr & (s_data_tlast | (cap_cnt_nx == cap_full)));
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      armed         <= 1'b0;
      cap_act       <= 1'b0;
      cap_cnt       <= '0;
      capture_done  <= 1'b0;
      capture_words <= '0;
    end else begin
      if (cap_wr) cap_cnt <= cap_cnt_nx;
      if (cap_stop) begin
        cap_act       <= 1'b0;
        armed         <= 1'b0;
        capture_done  <= 1'b1;
        capture_words <= 16'(cap_wr ? cap_cnt_nx : cap_cnt);
      end else begin
        if (cap_first) cap_act <= 1'b1;
        if (capture_arm && !cap_act) begin
          armed        <= 1'b1;
          capture_done <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (cap_wr && !s_axis_areset) mem[cap_addr] <= s_data_tdata;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) rd_data <= '0;
    else               rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_torwave_rx_check.sv
// tb_torwave_rx_check: directed stimulus against a cycle-stamped behavioural
// model of the torwave receiver, plus literal checkpoints.
module tb_torwave_rx_check;
  localparam int DEPTH = 16;
  localparam int PER   = 100;
  localparam int TOL   = 2;
  localparam int EXPW  = 8;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = 8'hff;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic        tready;
  logic        radio = 1'b0, arm = 1'b0, eclr = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        capture_done, error_flag;
  logic [15:0] capture_words, last_frame_words;
  logic [31:0] frame_count, last_period, start_to_sof;
  logic [3:0]  err_status;

  always #5 clk = ~clk;

  torwave_rx_check #(
    .capture_word_depth(DEPTH), .clocks_for_10ms(PER),
    .period_tolerance(TOL), .expected_frame_words(EXPW)
  ) dut (
    .s_axis_aclk(clk), .s_axis_areset(areset),
    .s_data_tdata(tdata), .s_data_tkeep(tkeep),
    .s_data_tvalid(tvalid), .s_data_tlast(tlast),
    .s_data_tuser(tuser), .s_data_tready(tready),
    .radio_start_10ms(radio), .capture_arm(arm), .err_clear(eclr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .capture_done(capture_done), .capture_words(capture_words),
    .frame_count(frame_count), .last_frame_words(last_frame_words),
    .last_period(last_period), .start_to_sof(start_to_sof),
    .err_status(err_status), .error_flag(error_flag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model state: everything is time-stamped by edge number
  longint      cyc = 0;
  bit          m_on = 0, m_rdyq = 0;
  bit          m_in;
  int          m_words, m_frames, m_lastw;
  longint      m_lastsof, m_period, m_lastpulse;
  bit          m_ref, m_pseen;
  logic [31:0] m_sts;
  bit   [3:0]  m_err;
  bit          m_flag, m_armed, m_act, m_done;
  int          m_capn, m_capw;
  logic [63:0] m_mem [DEPTH];
  bit          m_memv [DEPTH];
  logic [63:0] m_rd;
  bit          m_rdv;

  task automatic model_step();
    bit acc, sof, stop_now, was_act;
    bit [3:0] ne;
    cyc++;
    if (areset) begin
      m_on = 1; m_rdyq = 0; m_in = 0; m_words = 0; m_frames = 0;
      m_lastw = 0; m_ref = 0; m_period = 0; m_pseen = 0; m_sts = '1;
      m_err = 0; m_flag = 0; m_armed = 0; m_act = 0; m_done = 0;
      m_capn = 0; m_capw = 0; m_rd = '0; m_rdv = 1;
      return;
    end
    acc = tvalid && m_rdyq;
    m_rdyq = 1;
    m_rdv = m_memv[rd_addr];
    m_rd = m_mem[rd_addr];
    m_flag = |m_err;
    ne = 0;
    sof = acc && tuser;
    if (acc) begin
      if (tuser) begin
        if (m_in) ne[2:0] = ne[2:0] | 3'b101;
        m_in = 1;
        m_words = 1;
      end else if (m_in) m_words++;
      else ne[2] = 1;
      if (tlast && m_in) begin
        m_frames++;
        m_lastw = m_words;
        if (m_words != EXPW) ne[0] = 1;
        m_in = 0;
      end
`ifdef TORWAVE_RX_KEEP_CHECK_EN
      if (tlast) begin
        if (!(tkeep inside {8'h01, 8'h03, 8'h07, 8'h0f,
                            8'h1f, 8'h3f, 8'h7f, 8'hff})) ne[3] = 1;
      end else if (tkeep != 8'hff) ne[3] = 1;
`endif
    end
    if (sof) begin
      if (m_ref) begin
        m_period = cyc - m_lastsof;
        if (m_period > PER + TOL || m_period < PER - TOL) ne[1] = 1;
      end
      m_lastsof = cyc;
      m_ref = 1;
      m_sts = radio ? 32'd0 : (m_pseen ? 32'(cyc - m_lastpulse) : '1);
    end else if (eclr) m_ref = 0;
    if (radio) begin m_pseen = 1; m_lastpulse = cyc; end
    m_err = (eclr ? 4'd0 : m_err) | ne;
    was_act = m_act;
    stop_now = 0;
    if (acc) begin
      if (m_act && tuser) stop_now = 1;
      else if (m_act || (sof && m_armed)) begin
        if (!m_act) m_capn = 0;
        m_mem[m_capn] = tdata;
        m_memv[m_capn] = 1;
        m_capn++;
        m_act = 1;
        if (tlast || m_capn == DEPTH) stop_now = 1;
      end
    end
    if (stop_now) begin
      m_act = 0; m_armed = 0; m_done = 1; m_capw = m_capn;
    end else if (arm && !was_act) begin
      m_armed = 1; m_done = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_memv[i] = 0;
    forever begin
      @(negedge clk);
      if (m_on) begin
        chk("tready", tready, m_rdyq & !areset);
        chk("frame_count", frame_count, 32'(m_frames));
        chk("last_frame_words", last_frame_words, 16'(m_lastw));
        chk("last_period", last_period, 32'(m_period));
        chk("start_to_sof", start_to_sof, m_sts);
        chk("err_status", err_status, m_err);
        chk("error_flag", error_flag, m_flag);
        chk("capture_done", capture_done, m_done);
        chk("capture_words", capture_words, 16'(m_capw));
        if (m_rdv) chk("rd_data", rd_data, m_rd);
      end
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clear();
    eclr = 1; tick(); eclr = 0;
  endtask

  // beats 0..n-1 on consecutive cycles, next SOF 'period' cycles later
  task automatic frame(int n, int period, int trunc = -1,
                       logic [7:0] lkeep = 8'hff, bit psof = 0);
    for (int i = 0; i < period; i++) begin
      tvalid = (i < n);
      tuser  = (i == 0) || (i == trunc);
      tlast  = (i == n - 1);
      tkeep  = (i == n - 1) ? lkeep : 8'hff;
      tdata  = 64'(i);
      radio  = psof && (i == 0);
      tick();
    end
    tvalid = 0; tuser = 0; tlast = 0; radio = 0; tkeep = 8'hff;
  endtask

  initial begin
    bit kexp;
    idle(3);
    areset = 0;
    chk("rst_tready", tready, 1'b0);
    chk("rst_frame_count", frame_count, 32'd0);
    chk("rst_start_to_sof", start_to_sof, 32'hffffffff);
    chk("rst_err", err_status, 4'd0);
    chk("rst_capture_done", capture_done, 1'b0);
    idle(2);
    chk("tready_up", tready, 1'b1);

    repeat (3) frame(8, 100);
    chk("nom_frames", frame_count, 32'd3);
    chk("nom_words", last_frame_words, 16'd8);
    chk("nom_period", last_period, 32'd100);
    chk("nom_err", err_status, 4'd0);
    chk("no_pulse_sts", start_to_sof, 32'hffffffff);

    frame(8, 103);
    frame(8, 98);
    chk("late_err", err_status, 4'b0010);
    chk("late_flag", error_flag, 1'b1);
    frame(8, 100);
    pulse_clear();
    chk("clear_err", err_status, 4'd0);
    frame(8, 98);
    frame(8, 100);
    chk("early_period", last_period, 32'd98);
    chk("early_err", err_status, 4'd0);
    frame(8, 100);

    frame(7, 100);
    frame(8, 100, 5);
    chk("trunc_err", err_status & 4'b0101, 4'b0101);
    chk("trunc_frames", frame_count, 32'd11);
    chk("trunc_words", last_frame_words, 16'd3);
    pulse_clear();

    arm = 1; tick(); arm = 0;
    chk("armed_not_done", capture_done, 1'b0);
    frame(20, 100);
    chk("cap_words", capture_words, 16'd16);
    chk("cap_done", capture_done, 1'b1);
    rd_addr = 4'd5; tick();
    chk("rd_5", rd_data, 64'd5);
    rd_addr = 4'd15; tick();
    chk("rd_15", rd_data, 64'd15);
    pulse_clear();

    radio = 1; tick(); radio = 0;
    idle(36);
    frame(8, 100);
    chk("align_37", start_to_sof, 32'd37);
    frame(8, 100, -1, 8'hff, 1);
    chk("align_same", start_to_sof, 32'd0);

    tvalid = 1; tuser = 0; tick(); tvalid = 0;
    idle(1);
    chk("orphan", err_status[2], 1'b1);
    pulse_clear();

    frame(8, 4);
    areset = 1; tick(); areset = 0;
    idle(2);
    chk("midrst_frames", frame_count, 32'd0);
    frame(8, 100);
    chk("post_rst_frames", frame_count, 32'd1);
    chk("post_rst_sts", start_to_sof, 32'hffffffff);

    pulse_clear();
    frame(8, 100, -1, 8'h05);
`ifdef TORWAVE_RX_KEEP_CHECK_EN
    kexp = 1;
`else
    kexp = 0;
`endif
    chk("keep_err", err_status[3], kexp);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
